tcdm_bank: RTL
==============

Name: tcdm_bank

Overview:
- Single-port TCDM memory bank with byte enables, one per crossbar slave port, directly downstream of the TCDM crossbar.
- Accepts one request per cycle and returns one response per granted request after a fixed, parameterised latency.
- Zero-clears its whole array after every reset before granting any traffic.
- Detects and flags out-of-range word addresses.

Parameters:
- DATA_WIDTH, 32, data word width in bits; must be a multiple of 8.
- ADDR_WIDTH, 32, byte address width seen from the crossbar.
- BE_WIDTH, DATA_WIDTH/8, byte-enable width.
- NUM_BANKS, 2, number of interleaved banks; power of 2, >=1.
- DEPTH, 256, words per bank; >=2, not required to be a power of 2.
- LATENCY, 1, cycles from grant edge to response; allowed range 1..4.

Ports:
- clk_i  in  1  clock, all logic on the rising edge.
- resetn_i  in  1  reset, asynchronous, active-low.
- req_i  in  1  request valid; held by the master until granted.
- gnt_o  out  1  grant; a request is accepted when req_i & gnt_o at a rising edge.
- addr_i  in  ADDR_WIDTH  byte address.
- we_i  in  1  1 = write, 0 = read.
- be_i  in  BE_WIDTH  byte enables for writes.
- wdata_i  in  DATA_WIDTH  write data.
- rvalid_o  out  1  response valid, one cycle per accepted request.
- rdata_o  out  DATA_WIDTH  read data; 0 for writes and for errors.
- err_o  out  1  response error flag, qualified by rvalid_o.
- init_done_o  out  1  high once the clear sweep is complete.

Behaviour:
- Reset values (async, while resetn_i=0):
  - gnt_o=0, rvalid_o=0, rdata_o=0, err_o=0, init_done_o=0.
  - FSM=INIT, clear counter=0, response pipeline valid bits all 0.
- FSM INIT:
  - Each cycle writes all-zero to word[cnt], then cnt++.
  - After the write of word DEPTH-1 the FSM moves to READY, so INIT lasts exactly DEPTH cycles after reset release.
  - gnt_o=0 throughout; req_i is ignored, and the master keeps holding its request.
- FSM READY:
  - gnt_o = req_i (combinational); init_done_o=1 (registered).
  - READY is terminal; only reset returns the FSM to INIT.
- Address decode:
  - OFFSET = log2(BE_WIDTH) + log2(NUM_BANKS).
  - widx = addr_i >> OFFSET.
  - Bank-select and byte-offset bits are ignored.
  - widx >= DEPTH is an error.
- Accepted write:
  - Byte k of word[widx] is updated from wdata_i at the accept edge iff be_i[k]=1.
  - be_i=0 is legal and performs no update but still produces a response.
  - Response: rdata=0, err=0.
- Accepted read: the response carries word[widx] as stored before the accept edge.
- Error request:
  - Applies to both reads and writes.
  - No array update.
  - Response: rdata=0, err=1.
- Latency:
  - A request accepted at edge t gives rvalid_o=1 in the cycle following edge t+LATENCY-1.
  - LATENCY=1 means rvalid_o is high in the cycle immediately after the grant cycle.
  - Implementation: LATENCY-stage shift register of {valid, err, data}; stage 0 is loaded from the array read.
- Throughput and ordering:
  - One request per cycle, no stalls, no response backpressure.
  - Responses are in strict request order.
  - At most LATENCY responses are in flight.
- Read-after-write: a read accepted on the cycle after a write to the same word returns the newly written bytes.
- rvalid_o=0 cycles: rdata_o=0 and err_o=0.
- Reset mid-operation: in-flight responses are discarded (rvalid_o drops asynchronously), the FSM returns to INIT and the array is re-cleared.

Test Plan:
- Init: release reset with DEPTH=256 and req_i=1 held → gnt_o=0 for 256 cycles; gnt_o=1 and init_done_o=1 from cycle 256; a read of word 5 returns 0x00000000.
- Byte-enable write: with NUM_BANKS=2, BE_WIDTH=4, write addr 0x18 (widx 3), wdata 0xAABBCCDD, be 0b0101; then read addr 0x18 → rdata 0x00BB00DD, err 0, rvalid exactly 1 cycle after each grant.
- Back-to-back pipeline: LATENCY=3, write words 0..3 with values 0x11*(i+1), then 4 consecutive reads of words 0..3 → 4 consecutive rvalid cycles starting 3 cycles after the first read, data 0x11, 0x22, 0x33, 0x44 in order.
- Out of range: DEPTH=256, read addr 0x800 (widx 256) → rvalid with err=1 and rdata=0; a following write to the same address leaves the array unchanged (an in-range word 0 checksum is unchanged).
- Read-after-write: write word 7 = 0xDEADBEEF at cycle n and read word 7 at cycle n+1 → rdata 0xDEADBEEF.
- Reset mid-stream: with 3 reads in flight at LATENCY=3, pulse resetn_i low → rvalid_o drops immediately, the in-flight responses never appear, init repeats for DEPTH cycles, and previously written words read back as 0.

Source files
------------

// File: rtl/tcdm_bank.sv
`default_nettype none
// ============================================================================
// Module   : tcdm_bank
// Brief    : Single-port TCDM memory bank with byte enables. Zero-clears the
//            array after reset, then grants one request per cycle and returns
//            an in-order response after a fixed LATENCY. Flags out-of-range
//            word addresses.
// Revision : 1.0
// ============================================================================
module tcdm_bank #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned BE_WIDTH   = DATA_WIDTH / 8,
  parameter int unsigned NUM_BANKS  = 2,
  parameter int unsigned DEPTH      = 256,
  parameter int unsigned LATENCY    = 1
) (
  input  logic                  clk_i,
  input  logic                  resetn_i,
  input  logic                  req_i,
  output logic                  gnt_o,
  input  logic [ADDR_WIDTH-1:0] addr_i,
  input  logic                  we_i,
  input  logic [BE_WIDTH-1:0]   be_i,
  input  logic [DATA_WIDTH-1:0] wdata_i,
  output logic                  rvalid_o,
  output logic [DATA_WIDTH-1:0] rdata_o,
  output logic                  err_o,
  output logic                  init_done_o
);

  // Word index starts above the byte-offset and bank-select bits.
  localparam int unsigned          OFFSET   = $clog2(BE_WIDTH) + $clog2(NUM_BANKS);
  localparam int unsigned          IDX_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_WIDTH-1:0] DEPTH_A  = ADDR_WIDTH'(DEPTH);
  localparam logic [IDX_W-1:0]      LAST_IDX = IDX_W'(DEPTH - 1);

  typedef enum logic [0:0] {
    S_INIT  = 1'b0,
    S_READY = 1'b1
  } state_e;

  state_e           state_q, state_d;
  logic [IDX_W-1:0] cnt_q, cnt_d;
  logic             init_done_q, init_done_d;

  logic [ADDR_WIDTH-1:0] widx;
  logic [IDX_W-1:0]      idx;
  logic                  addr_err;
  logic                  accept;

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [BE_WIDTH-1:0]   wr_be;
  logic [IDX_W-1:0]      wr_idx;
  logic [DATA_WIDTH-1:0] wr_data;
  logic [DATA_WIDTH-1:0] rd_data;

  logic [LATENCY-1:0]                 pv_q, pv_d;
  logic [LATENCY-1:0]                 pe_q, pe_d;
  logic [LATENCY-1:0][DATA_WIDTH-1:0] pd_q, pd_d;

  // Address decode and handshake; grants only once the clear sweep is over.
  assign widx     = addr_i >> OFFSET;
  assign idx      = widx[IDX_W-1:0];
  assign addr_err = (widx >= DEPTH_A);
  assign gnt_o    = req_i & (state_q == S_READY);
  assign accept   = req_i & gnt_o;

  // Clear-sweep sequencing: walk every word once, then stay in READY.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (state_q == S_INIT) begin
      cnt_d = cnt_q + IDX_W'(1);
      if (cnt_q == LAST_IDX) begin
        state_d = S_READY;
        cnt_d   = '0;
      end
    end
    init_done_d = (state_d == S_READY);
  end

  // FSM, sweep counter and registered init_done flag.
  always_ff @(posedge clk_i or negedge resetn_i) begin
    if (!resetn_i) begin
      state_q     <= S_INIT;
      cnt_q       <= '0;
      init_done_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      init_done_q <= init_done_d;
    end
  end

  // Array write port: the sweep owns it in INIT, accepted in-range writes after.
  always_comb begin
    wr_be   = '0;
    wr_idx  = idx;
    wr_data = wdata_i;
    if (state_q == S_INIT) begin
      wr_be   = '1;
      wr_idx  = cnt_q;
      wr_data = '0;
    end else if (accept && we_i && !addr_err) begin
      wr_be   = be_i;
    end
  end

  // Byte-granular array update; contents are defined by the sweep, not reset.
  always_ff @(posedge clk_i) begin
    for (int b = 0; b < int'(BE_WIDTH); b++) begin
      if (wr_be[b]) begin
        mem_q[wr_idx][b*8 +: 8] <= wr_data[b*8 +: 8];
      end
    end
  end

  // Array read sees contents before the accept edge; gated so a bad index is never used.
  always_comb begin
    rd_data = '0;
    if (!addr_err) begin
      rd_data = mem_q[idx];
    end
  end

  // Response pipeline next-state: stage 0 captures the access, later stages shift.
  always_comb begin
    pv_d    = '0;
    pe_d    = '0;
    pd_d    = '0;
    pv_d[0] = accept;
    pe_d[0] = accept & addr_err;
    pd_d[0] = (accept && !we_i && !addr_err) ? rd_data : '0;
    for (int i = 1; i < int'(LATENCY); i++) begin
      pv_d[i] = pv_q[i-1];
      pe_d[i] = pe_q[i-1];
      pd_d[i] = pd_q[i-1];
    end
  end

  // Response pipeline registers; reset discards anything in flight.
  always_ff @(posedge clk_i or negedge resetn_i) begin
    if (!resetn_i) begin
      pv_q <= '0;
      pe_q <= '0;
      pd_q <= '0;
    end else begin
      pv_q <= pv_d;
      pe_q <= pe_d;
      pd_q <= pd_d;
    end
  end

  assign rvalid_o    = pv_q[LATENCY-1];
  assign err_o       = pe_q[LATENCY-1];
  assign rdata_o     = pd_q[LATENCY-1];
  assign init_done_o = init_done_q;

endmodule
`default_nettype wire
